core_result_collector: RTL and testbench

// - Sits directly downstream of the jimmy core array in the multicore top, replacing the

---
 rtl/core_result_collector.sv | 143 ++++++++++++++
 tb/tb_core_result_collector.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/core_result_collector.sv
// core_result_collector
// Captures each core's result on the falling edge of its output strobe, tracks which
// cores have finished, counts clk cycles until all are done, then sums the captured
// results one core per cycle into a saturating total.
//
// Ports:
//   clk          in   system clock (same divided clock as the cores)
//   reset        in   asynchronous, active-low reset
//   core_strobe  in   [NUM_CORES]           per-core output strobe
//   core_result  in   [NUM_CORES*RESULT_W]  per-core result, slice i = core i
//   core_done    out  [NUM_CORES]           core i result captured
//   all_done     out  all core_done bits set (combinational)
//   total        out  [TOTAL_W]             saturated sum, valid when total_valid
//   total_valid  out  total is final
//   cycle_count  out  [CYCLE_W]             clk cycles from reset release until all_done
module core_result_collector #(
  parameter int unsigned NUM_CORES = 16,
  parameter int unsigned RESULT_W  = 8,
  parameter int unsigned TOTAL_W   = 12,
  parameter int unsigned CYCLE_W   = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_CORES-1:0]          core_strobe,
  input  logic [NUM_CORES*RESULT_W-1:0] core_result,
  output logic [NUM_CORES-1:0]          core_done,
  output logic                          all_done,
  output logic [TOTAL_W-1:0]            total,
  output logic                          total_valid,
  output logic [CYCLE_W-1:0]            cycle_count
);

  localparam int unsigned IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam int unsigned ACC_W = TOTAL_W + 1;
  localparam int unsigned SUM_W = ((RESULT_W > TOTAL_W) ? RESULT_W : TOTAL_W) + 1;

  localparam logic [ACC_W-1:0]   ACC_MAX  = {1'b0, {TOTAL_W{1'b1}}};
  localparam logic [CYCLE_W-1:0] CYC_MAX  = '1;
  localparam logic [IDX_W-1:0]   IDX_LAST = IDX_W'(NUM_CORES - 1);

  localparam logic [1:0] ST_COLLECT = 2'd0;
  localparam logic [1:0] ST_SUM     = 2'd1;
  localparam logic [1:0] ST_DONE    = 2'd2;

  logic [NUM_CORES-1:0] strobe_q;
  logic [NUM_CORES-1:0] fall;
  logic [RESULT_W-1:0]  result_reg [NUM_CORES];

  logic [1:0]         state, state_d;
  logic [IDX_W-1:0]   idx, idx_d;
  logic [ACC_W-1:0]   acc, acc_d, acc_next;
  logic [SUM_W-1:0]   sum_raw;
  logic [TOTAL_W-1:0] total_d;
  logic               total_valid_d;

  assign fall     = strobe_q & ~core_strobe;
  assign all_done = &core_done;

  // Strobe history and first-capture-wins result registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      strobe_q  <= '0;
      core_done <= '0;
      for (int i = 0; i < int'(NUM_CORES); i++) begin
        result_reg[i] <= '0;
      end
    end else begin
      strobe_q <= core_strobe;
      for (int i = 0; i < int'(NUM_CORES); i++) begin
        if (fall[i] && !core_done[i]) begin
          result_reg[i] <= core_result[i*RESULT_W +: RESULT_W];
          core_done[i]  <= 1'b1;
        end
      end
    end
  end

  // Cycle counter: runs until all_done, saturates rather than wraps
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cycle_count <= '0;
    end else if (!all_done && (cycle_count != CYC_MAX)) begin
      cycle_count <= cycle_count + CYCLE_W'(1);
    end
  end

  // Saturating accumulate of the current core's result; acc never exceeds ACC_MAX
  always_comb begin
    sum_raw  = SUM_W'(acc) + SUM_W'(result_reg[idx]);
    acc_next = (sum_raw > SUM_W'(ACC_MAX)) ? ACC_MAX : ACC_W'(sum_raw);
  end

  // FSM state and datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_COLLECT;
      idx         <= '0;
      acc         <= '0;
      total       <= '0;
      total_valid <= 1'b0;
    end else begin
      state       <= state_d;
      idx         <= idx_d;
      acc         <= acc_d;
      total       <= total_d;
      total_valid <= total_valid_d;
    end
  end

  // FSM next-state and datapath next values
  always_comb begin
    state_d       = state;
    idx_d         = idx;
    acc_d         = acc;
    total_d       = total;
    total_valid_d = total_valid;
    case (state)
      ST_COLLECT: begin
        if (all_done) begin
          state_d = ST_SUM;
          idx_d   = '0;
          acc_d   = '0;
        end
      end
      ST_SUM: begin
        acc_d = acc_next;
        idx_d = idx + IDX_W'(1);
        if (idx == IDX_LAST) begin
          total_d       = acc_next[TOTAL_W-1:0];
          total_valid_d = 1'b1;
          state_d       = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_DONE;
      end
      default: begin
        state_d = ST_COLLECT;
      end
    endcase
  end

endmodule

// File: tb/tb_core_result_collector.sv
// Directed testbench for core_result_collector: three instances cover the default
// configuration, a narrow saturating total and a narrow saturating cycle counter.
module tb_core_result_collector;

  localparam int unsigned NC = 16;
  localparam int unsigned RW = 8;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Main instance (defaults)
  logic [NC-1:0]    m_strobe = '0;
  logic [NC*RW-1:0] m_result = '0;
  logic [NC-1:0]    m_done;
  logic             m_all;
  logic [11:0]      m_total;
  logic             m_valid;
  logic [15:0]      m_cyc;

  // Saturating-total instance (TOTAL_W=8)
  logic [NC-1:0]    s_strobe = '0;
  logic [NC*RW-1:0] s_result = '0;
  logic [NC-1:0]    s_done;
  logic             s_all;
  logic [7:0]       s_total;
  logic             s_valid;
  logic [15:0]      s_cyc;

  // Saturating-counter instance (CYCLE_W=4)
  logic [NC-1:0]    c_strobe = '0;
  logic [NC*RW-1:0] c_result = '0;
  logic [NC-1:0]    c_done;
  logic             c_all;
  logic [11:0]      c_total;
  logic             c_valid;
  logic [3:0]       c_cyc;

  core_result_collector u_main (
    .clk(clk), .reset(reset), .core_strobe(m_strobe), .core_result(m_result),
    .core_done(m_done), .all_done(m_all), .total(m_total), .total_valid(m_valid),
    .cycle_count(m_cyc)
  );

  core_result_collector #(.TOTAL_W(8)) u_sat (
    .clk(clk), .reset(reset), .core_strobe(s_strobe), .core_result(s_result),
    .core_done(s_done), .all_done(s_all), .total(s_total), .total_valid(s_valid),
    .cycle_count(s_cyc)
  );

  core_result_collector #(.CYCLE_W(4)) u_cyc (
    .clk(clk), .reset(reset), .core_strobe(c_strobe), .core_result(c_result),
    .core_done(c_done), .all_done(c_all), .total(c_total), .total_valid(c_valid),
    .cycle_count(c_cyc)
  );

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Hold reset for two edges, release 1ns after an edge
  task automatic pulse_reset();
    reset = 1'b0;
    tick(2);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #3;
    checks++; if (m_done !== 16'h0000) begin errors++; $display("FAIL reset_core_done got %h exp 0000", m_done); end
    checks++; if (m_all !== 1'b0) begin errors++; $display("FAIL reset_all_done got %b exp 0", m_all); end
    checks++; if (m_total !== 12'h000) begin errors++; $display("FAIL reset_total got %h exp 000", m_total); end
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_total_valid got %b exp 0", m_valid); end
    checks++; if (m_cyc !== 16'h0000) begin errors++; $display("FAIL reset_cycle_count got %h exp 0000", m_cyc); end
  endtask

  // Cores fall one per cycle; results 1..9,9,0.. sum to 54
  task automatic test_stagger();
    logic [NC-1:0] exp_mask;
    m_strobe = '1;
    for (int i = 0; i < int'(NC); i++) begin
      m_result[i*RW +: RW] = (i < 9) ? RW'(i + 1) : ((i == 9) ? 8'd9 : 8'd0);
    end
    pulse_reset();
    tick(1);
    exp_mask = '0;
    for (int i = 0; i < int'(NC); i++) begin
      m_strobe[i] = 1'b0;
      tick(1);
      exp_mask[i] = 1'b1;
      checks++; if (m_done !== exp_mask) begin errors++; $display("FAIL stagger_core_done[%0d] got %h exp %h", i, m_done, exp_mask); end
    end
    checks++; if (m_all !== 1'b1) begin errors++; $display("FAIL stagger_all_done got %b exp 1", m_all); end
    tick(NC);
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL stagger_valid_early got %b exp 0", m_valid); end
    checks++; if (m_total !== 12'h000) begin errors++; $display("FAIL stagger_total_early got %h exp 000", m_total); end
    tick(1);
    checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL stagger_valid got %b exp 1", m_valid); end
    checks++; if (m_total !== 12'h036) begin errors++; $display("FAIL stagger_total got %h exp 036", m_total); end
    checks++; if (m_cyc !== 16'd17) begin errors++; $display("FAIL stagger_cycle_count got %0d exp 17", m_cyc); end
    tick(5);
    checks++; if (m_total !== 12'h036 || m_valid !== 1'b1) begin errors++; $display("FAIL stagger_hold got %h/%b exp 036/1", m_total, m_valid); end
  endtask

  // All cores fall together with 0xFF each
  task automatic test_back_to_back();
    m_strobe = '1;
    m_result = {NC{8'hFF}};
    pulse_reset();
    tick(1);
    m_strobe = '0;
    tick(1);
    checks++; if (m_done !== 16'hFFFF) begin errors++; $display("FAIL simul_core_done got %h exp FFFF", m_done); end
    tick(NC + 1);
    checks++; if (m_total !== 12'hFF0) begin errors++; $display("FAIL simul_total got %h exp FF0", m_total); end
    checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL simul_valid got %b exp 1", m_valid); end
    checks++; if (m_cyc !== 16'd2) begin errors++; $display("FAIL simul_cycle_count got %0d exp 2", m_cyc); end
  endtask

  // Core 3 low at release (no edge), then two pulses 5 and 9; only 5 is kept
  task automatic test_first_capture();
    m_strobe = 16'hFFF7;
    m_result = '0;
    pulse_reset();
    tick(3);
    checks++; if (m_done[3] !== 1'b0) begin errors++; $display("FAIL low_at_release_done3 got %b exp 0", m_done[3]); end
    m_result[3*RW +: RW] = 8'd5;
    m_strobe[3] = 1'b1;
    tick(1);
    m_strobe[3] = 1'b0;
    tick(1);
    checks++; if (m_done[3] !== 1'b1) begin errors++; $display("FAIL first_capture_done3 got %b exp 1", m_done[3]); end
    m_result[3*RW +: RW] = 8'd9;
    m_strobe[3] = 1'b1;
    tick(1);
    m_strobe[3] = 1'b0;
    tick(1);
    m_strobe = '0;
    tick(1);
    checks++; if (m_done !== 16'hFFFF) begin errors++; $display("FAIL first_capture_all got %h exp FFFF", m_done); end
    tick(NC + 2);
    checks++; if (m_total !== 12'd5 || m_valid !== 1'b1) begin errors++; $display("FAIL first_capture_total got %0d/%b exp 5/1", m_total, m_valid); end
  endtask

  // 16 x 0x20 = 512 clamps to 0xFF with TOTAL_W=8
  task automatic test_saturate();
    s_strobe = '1;
    s_result = {NC{8'h20}};
    pulse_reset();
    tick(1);
    s_strobe = '0;
    tick(NC + 2);
    checks++; if (s_total !== 8'hFF) begin errors++; $display("FAIL sat_total got %h exp FF", s_total); end
    checks++; if (s_valid !== 1'b1) begin errors++; $display("FAIL sat_valid got %b exp 1", s_valid); end
  endtask

  // Core 15 never strobes; 4-bit counter parks at 0xF
  task automatic test_cycle_saturate();
    c_strobe = '1;
    c_result = {NC{8'h01}};
    pulse_reset();
    tick(1);
    c_strobe = 16'h8000;
    tick(30);
    checks++; if (c_cyc !== 4'hF) begin errors++; $display("FAIL cyc_sat_count got %h exp F", c_cyc); end
    checks++; if (c_all !== 1'b0) begin errors++; $display("FAIL cyc_sat_all_done got %b exp 0", c_all); end
    checks++; if (c_valid !== 1'b0) begin errors++; $display("FAIL cyc_sat_valid got %b exp 0", c_valid); end
    checks++; if (c_done !== 16'h7FFF) begin errors++; $display("FAIL cyc_sat_core_done got %h exp 7FFF", c_done); end
    c_strobe = '0;
  endtask

  // Reset lands mid-SUM, then a fresh run with different values
  task automatic test_reset_mid_sum();
    m_strobe = '1;
    m_result = {NC{8'h01}};
    pulse_reset();
    tick(1);
    m_strobe = '0;
    tick(6);
    reset = 1'b0;
    #2;
    checks++; if (m_done !== 16'h0000 || m_all !== 1'b0) begin errors++; $display("FAIL midsum_done got %h/%b exp 0000/0", m_done, m_all); end
    checks++; if (m_total !== 12'h000 || m_valid !== 1'b0 || m_cyc !== 16'h0000) begin errors++; $display("FAIL midsum_outputs got %h/%b/%h exp 000/0/0000", m_total, m_valid, m_cyc); end
    m_strobe = '1;
    m_result = {NC{8'h02}};
    tick(2);
    reset = 1'b1;
    tick(1);
    m_strobe = '0;
    tick(1);
    checks++; if (m_cyc !== 16'd2) begin errors++; $display("FAIL rerun_cycle_count got %0d exp 2", m_cyc); end
    tick(NC);
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL rerun_valid_early got %b exp 0", m_valid); end
    tick(1);
    checks++; if (m_total !== 12'd32 || m_valid !== 1'b1) begin errors++; $display("FAIL rerun_total got %0d/%b exp 32/1", m_total, m_valid); end
  endtask

  initial begin
    test_reset();
    test_stagger();
    test_back_to_back();
    test_first_capture();
    test_saturate();
    test_cycle_saturate();
    test_reset_mid_sum();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
